hazard_ctrl_unit: RTL and testbench

- Parametrised successor to the pipeline's hazard/forwarding control.
- Drives the five-stage datapath's pc_load, IFID_Ld, flush, sel_signal and forwardA/B.
- New capabilities:
  - ID-stage forwarding for the branch/jr compare.
  - Variable-latency data-memory handshake that freezes the whole pipe.
  - Memory timeout detection.
- Sits beside the datapath; consumes its register-address/control taps.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_ctrl_unit_fwd_sel.sv | 30 +++
 rtl/hazard_ctrl_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding control unit:
// forward-select encodings, memory-handshake FSM states, default widths
// and a saturating counter helper.
package hazard_pkg;

    // Default register-address width (32-entry register file)
    localparam int RA_W_DEFAULT = 5;

    // Operand-select encoding shared by EX and ID forwarding outputs
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_MEMWB = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;

    // Data-memory handshake FSM states
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } mem_state_e;

    // 32-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        logic [31:0] r;
        r = v;
        if (en && (v != 32'hFFFF_FFFF)) begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Combinational forwarding priority selector. Picks the youngest in-flight
// producer of a source register: EXMEM beats MEMWB, register 0 is never
// forwarded. When en is low the regfile value is always selected.
import hazard_pkg::*;

module fwd_sel #(
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic            en,
    input  logic [RA_W-1:0] src,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_we,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_we,
    output logic [1:0]      sel
);

    // Priority match: EXMEM first, then MEMWB, else regfile
    always_comb begin
        sel = FWD_RF;
        if (en) begin
            if (exmem_we && (exmem_rd != '0) && (exmem_rd == src)) begin
                sel = FWD_EXMEM;
            end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard detection and forwarding control for the five-stage pipeline.
// Produces EX and ID-compare forward selects, load-use / branch stalls,
// IFID flush on taken branches, and a whole-pipe freeze while a
// variable-latency data-memory access is outstanding, with a sticky
// timeout error. mem_state_dbg exposes the memory FSM state.
// Optional build macro HAZARD_PERF_EN adds saturating stall/hold/flush
// cycle counters.
//
// Handshake: the memory access is outstanding while mem_req=1 and
// mem_ack=0; the cycle in which mem_req=1 and mem_ack=1 completes it and
// that cycle is allowed to advance.
import hazard_pkg::*;

module hazard_ctrl_unit #(
    parameter int RA_W       = RA_W_DEFAULT,
    parameter int MEM_TO_W   = 4,
    parameter int MEM_TO_MAX = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] IFID_Rs,
    input  logic [RA_W-1:0] IFID_Rt,
    input  logic [RA_W-1:0] IDEX_Rs,
    input  logic [RA_W-1:0] IDEX_Rt,
    input  logic [RA_W-1:0] IDEX_Rd,
    input  logic            IDEX_reg_write,
    input  logic            IDEX_mem_read,
    input  logic [RA_W-1:0] EXMEM_Rd,
    input  logic            EXMEM_reg_write,
    input  logic            EXMEM_mem_read,
    input  logic [RA_W-1:0] MEMWB_Rd,
    input  logic            MEMWB_reg_write,
    input  logic            id_branch,
    input  logic            id_jr,
    input  logic            br_taken,
    input  logic            mem_req,
    input  logic            mem_ack,
    output logic [1:0]      forwardA,
    output logic [1:0]      forwardB,
    output logic [1:0]      fwdA_id,
    output logic [1:0]      fwdB_id,
    output logic            pc_load,
    output logic            IFID_Ld,
    output logic            sel_signal,
    output logic            flush,
    output logic            pipe_hold,
    output logic            mem_timeout,
`ifdef HAZARD_PERF_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     hold_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic [1:0]      mem_state_dbg
);

    localparam logic [MEM_TO_W-1:0] TO_LIMIT = MEM_TO_W'(MEM_TO_MAX);
    localparam logic [MEM_TO_W-1:0] TO_ONE   = MEM_TO_W'(1);

    mem_state_e          state_q, state_d;
    logic [MEM_TO_W-1:0] cnt_q, cnt_d;
    logic                mem_timeout_q, mem_timeout_d;
    logic                sel_hold_q, sel_hold_d;

    logic id_cmp;
    logic load_use;
    logic br_on_ex;
    logic br_on_mem_load;
    logic stall;
    logic hold;
    logic sel_now;

    // ---------------- forwarding ----------------
    fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .en       (1'b1),
        .src      (IDEX_Rs),
        .exmem_rd (EXMEM_Rd),
        .exmem_we (EXMEM_reg_write),
        .memwb_rd (MEMWB_Rd),
        .memwb_we (MEMWB_reg_write),
        .sel      (forwardA)
    );

    fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .en       (1'b1),
        .src      (IDEX_Rt),
        .exmem_rd (EXMEM_Rd),
        .exmem_we (EXMEM_reg_write),
        .memwb_rd (MEMWB_Rd),
        .memwb_we (MEMWB_reg_write),
        .sel      (forwardB)
    );

    // ID-stage compare operands only matter for branch / jr
    fwd_sel #(.RA_W(RA_W)) u_fwd_a_id (
        .en       (id_cmp),
        .src      (IFID_Rs),
        .exmem_rd (EXMEM_Rd),
        .exmem_we (EXMEM_reg_write),
        .memwb_rd (MEMWB_Rd),
        .memwb_we (MEMWB_reg_write),
        .sel      (fwdA_id)
    );

    fwd_sel #(.RA_W(RA_W)) u_fwd_b_id (
        .en       (id_cmp),
        .src      (IFID_Rt),
        .exmem_rd (EXMEM_Rd),
        .exmem_we (EXMEM_reg_write),
        .memwb_rd (MEMWB_Rd),
        .memwb_we (MEMWB_reg_write),
        .sel      (fwdB_id)
    );

    // Stall detection: producers that cannot be forwarded in time
    always_comb begin
        id_cmp   = id_branch | id_jr;
        load_use = IDEX_mem_read && (IDEX_Rd != '0) &&
                   ((IDEX_Rd == IFID_Rs) || (IDEX_Rd == IFID_Rt));
        br_on_ex = id_cmp && IDEX_reg_write && (IDEX_Rd != '0) &&
                   ((IDEX_Rd == IFID_Rs) || (IDEX_Rd == IFID_Rt));
        br_on_mem_load = id_cmp && EXMEM_mem_read && (EXMEM_Rd != '0) &&
                         ((EXMEM_Rd == IFID_Rs) || (EXMEM_Rd == IFID_Rt));
        stall = load_use | br_on_ex | br_on_mem_load;
    end

    // Memory FSM next state; hold is released combinationally on ack
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_timeout_d = mem_timeout_q;
        hold          = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = MEM_IDLE;
                end else begin
                    hold = 1'b1;
                    if (cnt_q == TO_LIMIT) begin
                        state_d = MEM_ERR;
                    end else begin
                        cnt_d = cnt_q + TO_ONE;
                    end
                end
            end
            MEM_ERR: begin
                hold = 1'b1;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
        if (state_d == MEM_ERR) begin
            mem_timeout_d = 1'b1;
        end
    end

    // Pipeline control outputs; a freeze dominates stall and flush
    always_comb begin
        sel_now    = hold ? sel_hold_q : !stall;
        sel_hold_d = sel_now;
        sel_signal = sel_now;
        pc_load    = !(hold | stall);
        IFID_Ld    = !(hold | stall);
        flush      = br_taken && !stall && !hold;
        pipe_hold  = hold;
        mem_timeout   = mem_timeout_q;
        mem_state_dbg = state_q;
    end

    // FSM, timeout counter, sticky error and held sel_signal registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= MEM_IDLE;
            cnt_q         <= '0;
            mem_timeout_q <= 1'b0;
            sel_hold_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_timeout_q <= mem_timeout_d;
            sel_hold_q    <= sel_hold_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] hold_cnt_q,  hold_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Next counter values; stalls count only when not masked by a freeze
    always_comb begin
        stall_cnt_d = sat_inc32(stall_cnt_q, stall && !hold);
        hold_cnt_d  = sat_inc32(hold_cnt_q, hold);
        flush_cnt_d = sat_inc32(flush_cnt_q, flush);
        stall_cnt   = stall_cnt_q;
        hold_cnt    = hold_cnt_q;
        flush_cnt   = flush_cnt_q;
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            hold_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. The driver applies one input vector
// per cycle just after the rising edge and queues the hand-computed output
// vector; the monitor pops and compares on the falling edge.
module tb_hazard_ctrl_unit;

    localparam int RA_W = 5;
    localparam int W    = 16;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic            clk = 1'b0;
    logic            rst;
    logic [RA_W-1:0] IFID_Rs, IFID_Rt, IDEX_Rs, IDEX_Rt, IDEX_Rd, EXMEM_Rd, MEMWB_Rd;
    logic            IDEX_reg_write, IDEX_mem_read, EXMEM_reg_write, EXMEM_mem_read;
    logic            MEMWB_reg_write, id_branch, id_jr, br_taken, mem_req, mem_ack;
    logic [1:0]      forwardA, forwardB, fwdA_id, fwdB_id, mem_state_dbg;
    logic            pc_load, IFID_Ld, sel_signal, flush, pipe_hold, mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0]     stall_cnt, hold_cnt, flush_cnt;
    logic [31:0]     s0, h0, f0;
`endif

    logic [W-1:0] exp_q[$];
    string        nm_q[$];
    int           n_chk  = 0;
    int           n_fail = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    hazard_ctrl_unit #(.RA_W(RA_W), .MEM_TO_W(4), .MEM_TO_MAX(12)) dut (
        .clk             (clk),
        .rst             (rst),
        .IFID_Rs         (IFID_Rs),
        .IFID_Rt         (IFID_Rt),
        .IDEX_Rs         (IDEX_Rs),
        .IDEX_Rt         (IDEX_Rt),
        .IDEX_Rd         (IDEX_Rd),
        .IDEX_reg_write  (IDEX_reg_write),
        .IDEX_mem_read   (IDEX_mem_read),
        .EXMEM_Rd        (EXMEM_Rd),
        .EXMEM_reg_write (EXMEM_reg_write),
        .EXMEM_mem_read  (EXMEM_mem_read),
        .MEMWB_Rd        (MEMWB_Rd),
        .MEMWB_reg_write (MEMWB_reg_write),
        .id_branch       (id_branch),
        .id_jr           (id_jr),
        .br_taken        (br_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .forwardA        (forwardA),
        .forwardB        (forwardB),
        .fwdA_id         (fwdA_id),
        .fwdB_id         (fwdB_id),
        .pc_load         (pc_load),
        .IFID_Ld         (IFID_Ld),
        .sel_signal      (sel_signal),
        .flush           (flush),
        .pipe_hold       (pipe_hold),
        .mem_timeout     (mem_timeout),
`ifdef HAZARD_PERF_EN
        .stall_cnt       (stall_cnt),
        .hold_cnt        (hold_cnt),
        .flush_cnt       (flush_cnt),
`endif
        .mem_state_dbg   (mem_state_dbg)
    );

    // Expected-vector packer: {fA, fB, fA_id, fB_id, pc, ifid, sel, flush, hold, timeout, state}
    function automatic logic [W-1:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                        input logic [1:0] fai, input logic [1:0] fbi,
                                        input logic pc, input logic ifd, input logic sel,
                                        input logic fl, input logic hd, input logic to,
                                        input logic [1:0] st);
        return {fa, fb, fai, fbi, pc, ifd, sel, fl, hd, to, st};
    endfunction

    // Quiet pipeline: advance, nothing forwarded
    function automatic logic [W-1:0] ev_idle();
        return ev(2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_IDLE);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clr();
        IFID_Rs = '0; IFID_Rt = '0; IDEX_Rs = '0; IDEX_Rt = '0; IDEX_Rd = '0;
        EXMEM_Rd = '0; MEMWB_Rd = '0;
        IDEX_reg_write = 1'b0; IDEX_mem_read = 1'b0;
        EXMEM_reg_write = 1'b0; EXMEM_mem_read = 1'b0; MEMWB_reg_write = 1'b0;
        id_branch = 1'b0; id_jr = 1'b0; br_taken = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Queue the expectation for the inputs now applied, then move to the next cycle
    task automatic chk(input logic [W-1:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e, act;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = nm_q.pop_front();
                act = {forwardA, forwardB, fwdA_id, fwdB_id, pc_load, IFID_Ld,
                       sel_signal, flush, pipe_hold, mem_timeout, mem_state_dbg};
                n_chk++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", nm, act, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        clr();
        @(posedge clk);
        #1;
        chk(ev_idle(), "reset_defaults");
        rst = 1'b1;

        // EX forwarding priority and register 0
        EXMEM_Rd = 5'd8; EXMEM_reg_write = 1'b1; MEMWB_Rd = 5'd8; MEMWB_reg_write = 1'b1;
        IDEX_Rs = 5'd8;
        chk(ev(2'd2, 2'd0, 2'd0, 2'd0, 1, 1, 1, 0, 0, 0, S_IDLE), "fwdA_exmem_prio");
        EXMEM_reg_write = 1'b0;
        chk(ev(2'd1, 2'd0, 2'd0, 2'd0, 1, 1, 1, 0, 0, 0, S_IDLE), "fwdA_memwb");
        IDEX_Rs = 5'd0; EXMEM_Rd = 5'd0; MEMWB_Rd = 5'd0; EXMEM_reg_write = 1'b1;
        chk(ev_idle(), "fwd_reg0_ignored");
        clr();
        IDEX_Rs = 5'd3; IDEX_Rt = 5'd3; MEMWB_Rd = 5'd3; MEMWB_reg_write = 1'b1;
        EXMEM_Rd = 5'd3; IFID_Rs = 5'd3;
        chk(ev(2'd1, 2'd1, 2'd0, 2'd0, 1, 1, 1, 0, 0, 0, S_IDLE), "fwdB_memwb_id_off");
        id_branch = 1'b1; IFID_Rt = 5'd5; EXMEM_Rd = 5'd5; EXMEM_reg_write = 1'b1;
        chk(ev(2'd1, 2'd1, 2'd1, 2'd2, 1, 1, 1, 0, 0, 0, S_IDLE), "fwd_id_enabled");
        clr();

        // Load-use stall for exactly one cycle, then bubble with load in MEM
        IDEX_mem_read = 1'b1; IDEX_reg_write = 1'b1; IDEX_Rd = 5'd9; IFID_Rt = 5'd9;
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, S_IDLE), "load_use_stall");
        IDEX_mem_read = 1'b0; IDEX_reg_write = 1'b0; IDEX_Rd = 5'd0;
        EXMEM_Rd = 5'd9; EXMEM_reg_write = 1'b1; EXMEM_mem_read = 1'b1;
        mem_req = 1'b1; mem_ack = 1'b1;
        chk(ev_idle(), "load_use_release");
        clr();
        IDEX_mem_read = 1'b1;
        chk(ev_idle(), "load_use_rd0");
        IDEX_Rd = 5'd9; IFID_Rt = 5'd9; br_taken = 1'b1;
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, S_IDLE), "load_use_vs_taken");
        clr();

        // Branch depending on an ALU result in EX, then forwarded from EXMEM
        id_branch = 1'b1; IDEX_reg_write = 1'b1; IDEX_Rd = 5'd4; IFID_Rs = 5'd4; br_taken = 1'b1;
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, S_IDLE), "branch_on_ex_stall");
        IDEX_reg_write = 1'b0; IDEX_Rd = 5'd0; EXMEM_Rd = 5'd4; EXMEM_reg_write = 1'b1;
        chk(ev(2'd0, 2'd0, 2'd2, 2'd0, 1, 1, 1, 1, 0, 0, S_IDLE), "branch_fwd_flush");
        clr();
        id_branch = 1'b1; IDEX_reg_write = 1'b1; IDEX_Rd = 5'd6; IFID_Rt = 5'd6;
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, S_IDLE), "branch_on_ex_rt");
        clr();
        id_jr = 1'b1; EXMEM_mem_read = 1'b1; EXMEM_reg_write = 1'b1; EXMEM_Rd = 5'd4;
        IFID_Rs = 5'd4; br_taken = 1'b1;
        chk(ev(2'd0, 2'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, S_IDLE), "jr_on_load_in_mem");
        clr();

        // Variable-latency access: 3 hold cycles, release on ack
`ifdef HAZARD_PERF_EN
        s0 = stall_cnt; h0 = hold_cnt; f0 = flush_cnt;
`endif
        mem_req = 1'b1; IDEX_mem_read = 1'b1; IDEX_Rd = 5'd7; IFID_Rs = 5'd7;
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, S_IDLE), "mem_req_issue_stall");
        IDEX_mem_read = 1'b0; br_taken = 1'b1;
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, S_WAIT), "wait1_hold_over_flush");
        br_taken = 1'b0;
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, S_WAIT), "wait2");
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, S_WAIT), "wait3");
        mem_ack = 1'b1; br_taken = 1'b1;
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 1, 1, 1, 1, 0, 0, S_WAIT), "ack_cycle_advances");
`ifdef HAZARD_PERF_EN
        n_chk++;
        if ((stall_cnt - s0) != 32'd1 || (hold_cnt - h0) != 32'd3 || (flush_cnt - f0) != 32'd1) begin
            n_fail++;
            $display("FAIL perf_counters: got stall+%0d hold+%0d flush+%0d expected 1 3 1",
                     stall_cnt - s0, hold_cnt - h0, flush_cnt - f0);
        end
`endif
        clr();
        chk(ev_idle(), "back_to_idle");

        // Timeout: 13 WAIT cycles without ack, then sticky ERR
        mem_req = 1'b1;
        chk(ev_idle(), "to_issue");
        for (int i = 1; i <= 13; i++) begin
            chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 0, 1, 0, S_WAIT), $sformatf("to_wait_%0d", i));
        end
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 0, 1, 1, S_ERR), "timeout_err");
        mem_req = 1'b0; mem_ack = 1'b1;
        chk(ev(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 0, 1, 1, S_ERR), "timeout_sticky");
        clr();
        rst = 1'b0;
        chk(ev_idle(), "async_reset_clears");
        rst = 1'b1;
        chk(ev_idle(), "after_reset_idle");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
